// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the matrix-storage arbiter: requester count and IDs,
// default storage geometry, the requester-id type and small one-hot helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ    = 3;
    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 32;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_INPUT = 2'd0;
    localparam req_id_t REQ_CALC  = 2'd1;
    localparam req_id_t REQ_DISP  = 2'd2;

    // Next requester in round-robin order, wrapping 2 -> 0.
    function automatic req_id_t next_id(input req_id_t id);
        req_id_t r;
        case (id)
            REQ_INPUT: r = REQ_CALC;
            REQ_CALC:  r = REQ_DISP;
            default:   r = REQ_INPUT;
        endcase
        return r;
    endfunction

    // Requester id to one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
        logic [NUM_REQ-1:0] r;
        case (id)
            REQ_INPUT: r = 3'b001;
            REQ_CALC:  r = 3'b010;
            REQ_DISP:  r = 3'b100;
            default:   r = 3'b000;
        endcase
        return r;
    endfunction

    // One-hot grant vector to requester id (zero vector maps to REQ_INPUT).
    function automatic req_id_t onehot_id(input logic [NUM_REQ-1:0] oh);
        req_id_t r;
        case (oh)
            3'b010:  r = REQ_CALC;
            3'b100:  r = REQ_DISP;
            default: r = REQ_INPUT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/storage_arbiter_if.sv
// -----------------------------------------------------------------------------
// storage_arbiter_if
// Bundles the requester-side handshake and the RAM-side command/read bus of the
// matrix-storage arbiter.
//   slave  modport : the arbiter (consumes requests, drives grants and RAM cmd)
//   master modport : the environment (requesters + RAM model)
// Signals: i_en, i_req, i_we, i_addr, i_wdata, i_mem_rdata (into arbiter);
//          o_gnt, o_rvalid, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata, o_busy.
// With ARB_LOCK_EN defined, adds i_lock (in) and o_lock_tmo (out).
// -----------------------------------------------------------------------------
interface storage_arbiter_if
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic [NUM_REQ-1:0]          i_en;
    logic [NUM_REQ-1:0]          i_req;
    logic [1:0]                  i_we;
    logic [NUM_REQ*ADDR_W-1:0]   i_addr;
    logic [2*DATA_W-1:0]         i_wdata;
    logic [NUM_REQ-1:0]          o_gnt;
    logic [NUM_REQ-1:0]          o_rvalid;
    logic [DATA_W-1:0]           o_rdata;
    logic                        o_mem_we;
    logic [ADDR_W-1:0]           o_mem_addr;
    logic [DATA_W-1:0]           o_mem_wdata;
    logic [DATA_W-1:0]           i_mem_rdata;
    logic                        o_busy;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]          i_lock;
    logic                        o_lock_tmo;
`endif

    modport slave (
        input  i_en, i_req, i_we, i_addr, i_wdata, i_mem_rdata,
`ifdef ARB_LOCK_EN
        input  i_lock,
        output o_lock_tmo,
`endif
        output o_gnt, o_rvalid, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
    );

    modport master (
        output i_en, i_req, i_we, i_addr, i_wdata, i_mem_rdata,
`ifdef ARB_LOCK_EN
        output i_lock,
        input  o_lock_tmo,
`endif
        input  o_gnt, o_rvalid, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
    );

endinterface

// File: rtl/rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational three-way round-robin picker.
//   elig : eligible requester mask
//   ptr  : highest-priority requester id (0..2)
//   gnt  : one-hot grant (zero when nothing is eligible)
// Search order is ptr, ptr+1, ptr+2 taken mod 3.
// -----------------------------------------------------------------------------
module rr_pick3
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig,
    input  req_id_t            ptr,
    output logic [NUM_REQ-1:0] gnt
);

    // First eligible requester among a, b, c in that order.
    function automatic logic [NUM_REQ-1:0] first3(input logic [NUM_REQ-1:0] e,
                                                  input req_id_t a,
                                                  input req_id_t b,
                                                  input req_id_t c);
        logic [NUM_REQ-1:0] r;
        if (e[a]) begin
            r = id_onehot(a);
        end else if (e[b]) begin
            r = id_onehot(b);
        end else if (e[c]) begin
            r = id_onehot(c);
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Rotate the search start to the pointer; an illegal pointer acts as 0.
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            REQ_CALC: gnt = first3(elig, REQ_CALC, REQ_DISP, REQ_INPUT);
            REQ_DISP: gnt = first3(elig, REQ_DISP, REQ_INPUT, REQ_CALC);
            default:  gnt = first3(elig, REQ_INPUT, REQ_CALC, REQ_DISP);
        endcase
    end

endmodule

// File: rtl/storage_arbiter.sv
// -----------------------------------------------------------------------------
// storage_arbiter
// Round-robin arbiter sharing the single-port matrix storage RAM between the
// input subsystem (write), calculator core (read/write) and display (read).
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   bus    : storage_arbiter_if.slave (requests, grants, read return, RAM cmd)
// An accept (req & gnt at a clock edge) registers the RAM command for the
// next cycle; a read returns o_rvalid to its originator MEM_RD_LAT+1 cycles
// after the accept. o_gnt is combinational and forced low during reset.
// Optional build macro ARB_LOCK_EN: adds i_lock/o_lock_tmo so a requester can
// hold the grant for up to LOCK_MAX consecutive accepts.
// -----------------------------------------------------------------------------
module storage_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int MEM_RD_LAT = 1,
    parameter int LOCK_MAX   = 64
)(
    input  logic              clk,
    input  logic              rst_n,
    storage_arbiter_if.slave  bus
);

    if (MEM_RD_LAT < 1 || MEM_RD_LAT > 4 || LOCK_MAX < 1) begin : g_bad_param
        $error("storage_arbiter: MEM_RD_LAT must be 1..4 and LOCK_MAX >= 1");
    end

    req_id_t              rr_ptr_r;
    req_id_t              rr_ptr_nxt_s;
    logic [NUM_REQ-1:0]   elig_s;
    logic [NUM_REQ-1:0]   pick_gnt_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic                 acc_s;
    req_id_t              acc_id_s;
    logic                 acc_we_s;
    logic [ADDR_W-1:0]    acc_addr_s;
    logic [DATA_W-1:0]    acc_wdata_s;
    logic                 mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [DATA_W-1:0]    mem_wdata_r;
    // One-hot read tags: a non-zero entry is both the valid bit and the id.
    logic [NUM_REQ-1:0]   rd_pipe_r     [0:MEM_RD_LAT];
    logic [NUM_REQ-1:0]   rd_pipe_nxt_s [0:MEM_RD_LAT];
    logic                 busy_r;
    logic                 busy_nxt_s;

`ifdef ARB_LOCK_EN
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);
    logic                 lock_act_r;
    logic                 lock_act_nxt_s;
    req_id_t              lock_id_r;
    req_id_t              lock_id_nxt_s;
    logic [LOCK_W-1:0]    lock_cnt_r;
    logic [LOCK_W-1:0]    lock_cnt_nxt_s;
    logic [LOCK_W-1:0]    lock_run_s;
    logic                 lock_tmo_r;
    logic                 lock_tmo_nxt_s;
`endif

    assign elig_s = bus.i_req & bus.i_en;

    rr_pick3 u_pick (
        .elig (elig_s),
        .ptr  (rr_ptr_r),
        .gnt  (pick_gnt_s)
    );

    // Grant: a live lock holder overrides the round-robin pick; none in reset.
    always_comb begin
        gnt_s = 3'b000;
        if (!rst_n) begin
            gnt_s = 3'b000;
`ifdef ARB_LOCK_EN
        end else if (lock_act_r && elig_s[lock_id_r]) begin
            gnt_s = id_onehot(lock_id_r);
`endif
        end else begin
            gnt_s = pick_gnt_s;
        end
    end

    // Select the accepted requester's command fields.
    always_comb begin
        acc_s       = |gnt_s;
        acc_id_s    = onehot_id(gnt_s);
        acc_we_s    = 1'b0;
        acc_addr_s  = mem_addr_r;
        acc_wdata_s = mem_wdata_r;
        case (acc_id_s)
            REQ_INPUT: begin
                acc_we_s    = bus.i_we[0];
                acc_addr_s  = bus.i_addr[0 +: ADDR_W];
                acc_wdata_s = bus.i_wdata[0 +: DATA_W];
            end
            REQ_CALC: begin
                acc_we_s    = bus.i_we[1];
                acc_addr_s  = bus.i_addr[ADDR_W +: ADDR_W];
                acc_wdata_s = bus.i_wdata[DATA_W +: DATA_W];
            end
            REQ_DISP: begin
                acc_we_s    = 1'b0;
                acc_addr_s  = bus.i_addr[2*ADDR_W +: ADDR_W];
                acc_wdata_s = mem_wdata_r;
            end
            default: begin
                acc_we_s    = 1'b0;
                acc_addr_s  = mem_addr_r;
                acc_wdata_s = mem_wdata_r;
            end
        endcase
    end

    // Next state of the read-tag pipeline and the in-flight flag.
    always_comb begin
        rd_pipe_nxt_s[0] = (acc_s && !acc_we_s) ? gnt_s : 3'b000;
        for (int i = 1; i <= MEM_RD_LAT; i++) begin
            rd_pipe_nxt_s[i] = rd_pipe_r[i-1];
        end
        busy_nxt_s = 1'b0;
        for (int i = 0; i <= MEM_RD_LAT; i++) begin
            busy_nxt_s = busy_nxt_s | (|rd_pipe_nxt_s[i]);
        end
    end

    // Pointer and lock bookkeeping for the next cycle.
    always_comb begin
        rr_ptr_nxt_s = rr_ptr_r;
`ifdef ARB_LOCK_EN
        lock_act_nxt_s = lock_act_r;
        lock_id_nxt_s  = lock_id_r;
        lock_cnt_nxt_s = lock_cnt_r;
        lock_tmo_nxt_s = 1'b0;
        // Run length including this accept; restarts if a different id wins.
        lock_run_s     = (lock_act_r && (lock_id_r == acc_id_s)) ?
                         (lock_cnt_r + {{(LOCK_W-1){1'b0}}, 1'b1}) :
                         {{(LOCK_W-1){1'b0}}, 1'b1};
        if (acc_s) begin
            if (bus.i_lock[acc_id_s]) begin
                if (lock_run_s >= LOCK_W'(LOCK_MAX)) begin
                    lock_act_nxt_s = 1'b0;
                    lock_cnt_nxt_s = {LOCK_W{1'b0}};
                    lock_tmo_nxt_s = 1'b1;
                    rr_ptr_nxt_s   = next_id(acc_id_s);
                end else begin
                    lock_act_nxt_s = 1'b1;
                    lock_id_nxt_s  = acc_id_s;
                    lock_cnt_nxt_s = lock_run_s;
                end
            end else begin
                lock_act_nxt_s = 1'b0;
                lock_cnt_nxt_s = {LOCK_W{1'b0}};
                rr_ptr_nxt_s   = next_id(acc_id_s);
            end
        end else if (lock_act_r && !elig_s[lock_id_r]) begin
            lock_act_nxt_s = 1'b0;
            lock_cnt_nxt_s = {LOCK_W{1'b0}};
        end else begin
            lock_act_nxt_s = lock_act_r;
        end
`else
        if (acc_s) begin
            rr_ptr_nxt_s = next_id(acc_id_s);
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
`endif
    end

    // State registers: command register, read pipeline, pointer, lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r    <= REQ_INPUT;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            for (int i = 0; i <= MEM_RD_LAT; i++) begin
                rd_pipe_r[i] <= 3'b000;
            end
            busy_r      <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_act_r  <= 1'b0;
            lock_id_r   <= REQ_INPUT;
            lock_cnt_r  <= {LOCK_W{1'b0}};
            lock_tmo_r  <= 1'b0;
`endif
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
            mem_we_r <= acc_s && acc_we_s;
            if (acc_s) begin
                mem_addr_r  <= acc_addr_s;
                mem_wdata_r <= acc_wdata_s;
            end
            for (int i = 0; i <= MEM_RD_LAT; i++) begin
                rd_pipe_r[i] <= rd_pipe_nxt_s[i];
            end
            busy_r <= busy_nxt_s;
`ifdef ARB_LOCK_EN
            lock_act_r <= lock_act_nxt_s;
            lock_id_r  <= lock_id_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            lock_tmo_r <= lock_tmo_nxt_s;
`endif
        end
    end

    assign bus.o_gnt       = gnt_s;
    assign bus.o_rvalid    = rd_pipe_r[MEM_RD_LAT];
    assign bus.o_rdata     = bus.i_mem_rdata;
    assign bus.o_mem_we    = mem_we_r;
    assign bus.o_mem_addr  = mem_addr_r;
    assign bus.o_mem_wdata = mem_wdata_r;
    assign bus.o_busy      = busy_r;
`ifdef ARB_LOCK_EN
    assign bus.o_lock_tmo  = lock_tmo_r;
`endif

endmodule
